tcb_sub_mem: RTL and testbench

// - TCB subordinate (responder) with an internal byte-addressed memory. It is the far end of a TCB manager.
// - Accepts one request per cycle and returns the read data and status exactly PHY.DLY cycles after the handshake.
// - Used as on-chip SRAM behind TCB interconnect, and as the golden responder in bus-level benches.

---
 rtl/tcb_sub_mem_pkg.sv | 47 ++++
 rtl/tcb_sub_mem_rsp_dly.sv | 41 ++++
 rtl/tcb_sub_mem.sv | 96 +++++++++
 tb/tb_tcb_sub_mem.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcb_sub_mem_pkg.sv
// tcb_sub_mem_pkg: TCB bus parameter types, request/response fields and lane helpers.
package tcb_sub_mem_pkg;

    typedef enum logic {TCB_REFERENCE, TCB_MEMORY} tcb_par_mod_t;
    typedef enum logic {TCB_LOGARITHMIC, TCB_BYTE_ENA} tcb_par_siz_t;
    typedef enum logic {TCB_ALIGNED, TCB_UNALIGNED} tcb_par_lgn_t;
    typedef enum logic {TCB_DESCENDING, TCB_ASCENDING} tcb_par_ord_t;

    typedef struct packed {
        int unsigned  DLY;
        int unsigned  SLW;
        int unsigned  ABW;
        int unsigned  DBW;
        tcb_par_mod_t MOD;
        tcb_par_siz_t SIZ;
        tcb_par_lgn_t LGN;
        tcb_par_ord_t ORD;
    } tcb_par_phy_t;

    localparam tcb_par_phy_t TCB_PAR_PHY_DEF = '{
        DLY: 1, SLW: 8, ABW: 32, DBW: 32,
        MOD: TCB_REFERENCE, SIZ: TCB_LOGARITHMIC, LGN: TCB_ALIGNED, ORD: TCB_DESCENDING
    };

    typedef struct packed {
        logic inc;
        logic rpt;
        logic lck;
    } tcb_req_cmd_def_t;

    typedef struct packed {
        logic err;
    } tcb_rsp_sts_def_t;

    localparam int unsigned TCB_BEN_MAX = 128;

    function automatic int unsigned tcb_siz_max(input tcb_par_phy_t phy);
        return $clog2(phy.DBW / phy.SLW);
    endfunction

    // Wide mask; callers truncate to their own lane count.
    function automatic logic [TCB_BEN_MAX-1:0] tcb_siz2ben(input int unsigned siz, input int unsigned adr,
                                                           input int unsigned byt);
        return ((TCB_BEN_MAX'(1) << (1 << siz)) - TCB_BEN_MAX'(1)) << (adr & (byt - 1));
    endfunction

endpackage

// File: rtl/tcb_sub_mem_rsp_dly.sv
// tcb_sub_mem_rsp_dly: DLY-stage response pipeline; only the valid bits are reset.
module tcb_sub_mem_rsp_dly #(
    parameter int unsigned DLY = 1,
    parameter int unsigned DBW = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vld_i,
    input  logic [DBW-1:0] rdt_i,
    input  logic           sts_i,
    output logic           vld_o,
    output logic [DBW-1:0] rdt_o,
    output logic           sts_o
);

    logic [DLY-1:0]          vld_q, vld_d;
    logic [DLY-1:0]          sts_q, sts_d;
    logic [DLY-1:0][DBW-1:0] rdt_q, rdt_d;

    always_comb begin
        vld_d = DLY'({vld_q, vld_i});
        sts_d = DLY'({sts_q, sts_i});
        rdt_d = (DLY*DBW)'({rdt_q, rdt_i});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
        rdt_q <= rdt_d;
        sts_q <= sts_d;
    end

    // Data stages are not reset, so gate them to keep idle outputs at zero.
    assign vld_o = vld_q[DLY-1];
    assign rdt_o = vld_o ? rdt_q[DLY-1] : '0;
    assign sts_o = vld_o & sts_q[DLY-1];

endmodule

// File: rtl/tcb_sub_mem.sv
// tcb_sub_mem: TCB subordinate with an internal byte-addressed memory.
// Requests are decoded and checked here; responses travel through a fixed-latency pipeline.
module tcb_sub_mem
    import tcb_sub_mem_pkg::*;
#(
    parameter tcb_par_phy_t PHY     = TCB_PAR_PHY_DEF,
    parameter int unsigned  MEM_SIZ = 4096,
    localparam int unsigned ABW     = PHY.ABW,
    localparam int unsigned DBW     = PHY.DBW,
    localparam int unsigned SZW     = $clog2($clog2(PHY.DBW / PHY.SLW) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tcb_vld,
    output logic             tcb_rdy,
    input  tcb_req_cmd_def_t tcb_req_cmd,
    input  logic             tcb_req_wen,
    input  logic [ABW-1:0]   tcb_req_adr,
    input  logic [SZW-1:0]   tcb_req_siz,
    input  logic [DBW-1:0]   tcb_req_wdt,
    output logic             tcb_rsp_vld,
    output logic [DBW-1:0]   tcb_rsp_rdt,
    output tcb_rsp_sts_def_t tcb_rsp_sts
);

    localparam int unsigned BYT  = DBW / 8;
    localparam int unsigned OFW  = $clog2(BYT);
    localparam int unsigned ROWS = MEM_SIZ / BYT;
    localparam int unsigned RW   = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int unsigned SZM  = tcb_siz_max(PHY);
    localparam bit          REF  = PHY.MOD == TCB_REFERENCE;

    if (PHY.SIZ != TCB_LOGARITHMIC || PHY.LGN != TCB_ALIGNED || PHY.ORD != TCB_DESCENDING ||
        PHY.DLY < 1 || PHY.SLW != 8 || MEM_SIZ < BYT || (MEM_SIZ & (MEM_SIZ - 1)) != 0) begin : g_cfg_err
        $error("tcb_sub_mem: unsupported configuration");
    end

    logic               rdy_q, rdy_d;
    logic               trn, err;
    logic [ABW:0]       cnt;
    logic [BYT-1:0]     ben, mem_ben_d;
    logic [OFW-1:0]     off;
    logic [OFW+2:0]     sft;
    logic [RW-1:0]      row;
    logic [DBW-1:0]     msk, mem_wdt_d, rdt_c, rdt_d;
    logic               rsp_err;
    logic [BYT-1:0][7:0] mem_q [ROWS];
    logic               unused;

    assign unused  = ^tcb_req_cmd;
    assign rdy_d   = 1'b1;
    assign tcb_rdy = rdy_q;
    assign trn     = tcb_vld & rdy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_q <= 1'b0;
        else     rdy_q <= rdy_d;
    end

    // Upper address bits only feed the range check; the row index simply drops them.
    always_comb begin
        cnt = (ABW+1)'(1) << tcb_req_siz;
        err = (|(tcb_req_adr & ABW'(cnt - 1))) | (({1'b0, tcb_req_adr} + cnt) > (ABW+1)'(MEM_SIZ)) |
              (tcb_req_siz > SZW'(SZM));
        off = tcb_req_adr[OFW-1:0];
        sft = {off, 3'b000};
        row = RW'(tcb_req_adr >> OFW);
        ben = BYT'(tcb_siz2ben(32'(tcb_req_siz), 32'(off), BYT));
        for (int b = 0; b < BYT; b++) msk[8*b +: 8] = {8{ben[b]}};
        mem_wdt_d = REF ? tcb_req_wdt << sft : tcb_req_wdt;
        mem_ben_d = {BYT{trn & tcb_req_wen & ~err}} & ben;
        rdt_c     = mem_q[row] & msk;
        rdt_d     = (tcb_req_wen | err) ? '0 : (REF ? rdt_c >> sft : rdt_c);
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BYT; b++) if (mem_ben_d[b]) mem_q[row][b] <= mem_wdt_d[8*b +: 8];
    end

    tcb_sub_mem_rsp_dly #(
        .DLY (PHY.DLY),
        .DBW (DBW)
    ) u_rsp_dly (
        .clk   (clk),
        .rst   (rst),
        .vld_i (trn),
        .rdt_i (rdt_d),
        .sts_i (err),
        .vld_o (tcb_rsp_vld),
        .rdt_o (tcb_rsp_rdt),
        .sts_o (rsp_err)
    );

    assign tcb_rsp_sts = tcb_rsp_sts_def_t'(rsp_err);

endmodule

// File: tb/tb_tcb_sub_mem.sv
// tb_tcb_sub_mem: two subordinates (REFERENCE/DLY=1 and MEMORY/DLY=3) on one request stream,
// checked every cycle against a byte-array model plus literal expectations.
module tb_tcb_sub_mem;
    import tcb_sub_mem_pkg::*;

    localparam tcb_par_phy_t PHY0 = '{DLY: 1, SLW: 8, ABW: 32, DBW: 32, MOD: TCB_REFERENCE,
                                      SIZ: TCB_LOGARITHMIC, LGN: TCB_ALIGNED, ORD: TCB_DESCENDING};
    localparam tcb_par_phy_t PHY1 = '{DLY: 3, SLW: 8, ABW: 32, DBW: 32, MOD: TCB_MEMORY,
                                      SIZ: TCB_LOGARITHMIC, LGN: TCB_ALIGNED, ORD: TCB_DESCENDING};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             vld = 1'b0;
    logic             wen = 1'b0;
    logic [31:0]      adr = '0;
    logic [1:0]       siz = '0;
    logic [31:0]      wdt = '0;
    tcb_req_cmd_def_t cmd = '0;
    logic             rdy0, rdy1, rv0, rv1;
    logic [31:0]      rdt0, rdt1;
    tcb_rsp_sts_def_t sts0, sts1;

    int checks = 0;
    int passes = 0;
    int edge_n = 0;
    logic rdy_m = 1'b0;

    logic [7:0]  mem_m [2][4096];
    logic        ev [2][16];
    logic [31:0] er [2][16];
    logic        ee [2][16];
    logic [31:0] last_rdt [2];
    logic        last_err [2];
    logic [31:0] obs_rdt [2];
    logic        obs_err [2];
    int          obs_cnt [2];

    always #5 clk = ~clk;

    tcb_sub_mem #(.PHY(PHY0), .MEM_SIZ(4096)) dut0 (
        .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy0), .tcb_req_cmd(cmd), .tcb_req_wen(wen),
        .tcb_req_adr(adr), .tcb_req_siz(siz), .tcb_req_wdt(wdt),
        .tcb_rsp_vld(rv0), .tcb_rsp_rdt(rdt0), .tcb_rsp_sts(sts0)
    );

    tcb_sub_mem #(.PHY(PHY1), .MEM_SIZ(4096)) dut1 (
        .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy1), .tcb_req_cmd(cmd), .tcb_req_wen(wen),
        .tcb_req_adr(adr), .tcb_req_siz(siz), .tcb_req_wdt(wdt),
        .tcb_rsp_vld(rv1), .tcb_rsp_rdt(rdt1), .tcb_rsp_sts(sts1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
    endtask

    // Byte-array view of the transfer: byte k of the access lives at address adr+k and rides
    // bus lane k (REFERENCE, d=0) or lane adr%4+k (MEMORY, d=1).
    task automatic model_xfer(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                              input logic [31:0] wd, output logic [31:0] r, output logic e);
        int n, o, lane;
        n = 1 << s;
        o = int'(a % 4);
        e = (a % n != 0) || (longint'(a) + n > 4096) || (n > 4);
        r = '0;
        if (!e) for (int k = 0; k < n; k++) begin
            lane = d ? o + k : k;
            if (w) mem_m[d][a + k] = wd[8*lane +: 8];
            else   r[8*lane +: 8] = mem_m[d][a + k];
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] r;
        logic        e;
        int          s;
        if (rst) begin
            rdy_m = 1'b0;
            for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) ev[d][i] = 1'b0;
        end else begin
            if (vld && rdy_m) for (int d = 0; d < 2; d++) begin
                model_xfer(d, wen, adr, siz, wdt, r, e);
                s = (edge_n + (d ? 3 : 1) - 1) % 16;
                ev[d][s] = 1'b1;
                er[d][s] = r;
                ee[d][s] = e;
                last_rdt[d] = r;
                last_err[d] = e;
            end
            rdy_m = 1'b1;
        end
        edge_n++;
    end

    always @(negedge clk) begin
        logic        v, rd, e;
        logic [31:0] t;
        int          s;
        if (edge_n > 0) for (int d = 0; d < 2; d++) begin
            v  = d ? rv1 : rv0;
            rd = d ? rdy1 : rdy0;
            t  = d ? rdt1 : rdt0;
            e  = d ? sts1.err : sts0.err;
            s  = (edge_n - 1) % 16;
            if (rst) begin
                for (int i = 0; i < 16; i++) ev[d][i] = 1'b0;
                chk($sformatf("rst_vld%0d", d), {31'b0, v}, 32'd0);
                chk($sformatf("rst_rdy%0d", d), {31'b0, rd}, 32'd0);
                chk($sformatf("rst_rdt%0d", d), t, 32'd0);
                chk($sformatf("rst_sts%0d", d), {31'b0, e}, 32'd0);
            end else begin
                chk($sformatf("rsp_vld%0d", d), {31'b0, v}, {31'b0, ev[d][s]});
                chk($sformatf("rdy%0d", d), {31'b0, rd}, {31'b0, rdy_m});
                if (ev[d][s]) begin
                    chk($sformatf("rsp_rdt%0d", d), t, er[d][s]);
                    chk($sformatf("rsp_err%0d", d), {31'b0, e}, {31'b0, ee[d][s]});
                    ev[d][s] = 1'b0;
                end
            end
            if (v) begin
                obs_rdt[d] = t;
                obs_err[d] = e;
                obs_cnt[d]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        int t = 0;
        while (!(rdy0 && rdy1) && t < 20) begin
            tick();
            t++;
        end
        chk("rdy_wait", {31'b0, rdy0 & rdy1}, 32'd1);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
        wait_rdy();
        vld = 1'b1; wen = w; adr = a; siz = s; wdt = wd;
        tick();
        vld = 1'b0;
    endtask

    task automatic single(input string nm, input logic w, input logic [31:0] a, input logic [1:0] s,
                          input logic [31:0] wd, input logic [31:0] r0, input logic e0,
                          input logic [31:0] r1, input logic e1);
        int c0, c1;
        c0 = obs_cnt[0];
        c1 = obs_cnt[1];
        issue(w, a, s, wd);
        repeat (5) tick();
        chk({nm, "/model_rdt0"}, last_rdt[0], r0);
        chk({nm, "/model_rdt1"}, last_rdt[1], r1);
        chk({nm, "/model_err0"}, {31'b0, last_err[0]}, {31'b0, e0});
        chk({nm, "/model_err1"}, {31'b0, last_err[1]}, {31'b0, e1});
        chk({nm, "/cnt0"}, obs_cnt[0] - c0, 32'd1);
        chk({nm, "/cnt1"}, obs_cnt[1] - c1, 32'd1);
        chk({nm, "/rdt0"}, obs_rdt[0], r0);
        chk({nm, "/rdt1"}, obs_rdt[1], r1);
        chk({nm, "/err0"}, {31'b0, obs_err[0]}, {31'b0, e0});
        chk({nm, "/err1"}, {31'b0, obs_err[1]}, {31'b0, e1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, c1, r;
        for (int d = 0; d < 2; d++) obs_cnt[d] = 0;
        tick();
        chk("reset_rdy0", {31'b0, rdy0}, 32'd0);
        chk("reset_vld1", {31'b0, rv1}, 32'd0);
        chk("reset_rdt1", rdt1, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        // Prefill the regions the random phase reads from.
        wait_rdy();
        vld = 1'b1; wen = 1'b1; siz = 2'd2;
        for (int i = 0; i < 32; i++) begin
            adr = (i < 16) ? 32'(i * 4) : 32'(32'hFC0 + (i - 16) * 4);
            wdt = 32'hC0DE_0000 + adr;
            tick();
        end
        vld = 1'b0;
        repeat (4) tick();
        // Eight back-to-back reads with vld held high.
        c0 = obs_cnt[0];
        c1 = obs_cnt[1];
        wait_rdy();
        vld = 1'b1; wen = 1'b0; siz = 2'd2;
        for (int i = 0; i < 8; i++) begin
            adr = 32'(i * 4);
            tick();
        end
        vld = 1'b0;
        repeat (5) tick();
        chk("b2b/cnt0", obs_cnt[0] - c0, 32'd8);
        chk("b2b/cnt1", obs_cnt[1] - c1, 32'd8);
        chk("b2b/last0", obs_rdt[0], 32'hC0DE_001C);
        chk("b2b/last1", obs_rdt[1], 32'hC0DE_001C);
        // Directed transfers with hand-computed results.
        single("wr_word",   1'b1, 32'h10,   2'd2, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 1'b0);
        single("rd_word",   1'b0, 32'h10,   2'd2, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);
        single("wr_byte",   1'b1, 32'h13,   2'd0, 32'h5A00_005A, 32'h0, 1'b0, 32'h0, 1'b0);
        single("rd_word2",  1'b0, 32'h10,   2'd2, 32'h0, 32'h5AAD_BEEF, 1'b0, 32'h5AAD_BEEF, 1'b0);
        single("rd_half",   1'b0, 32'h12,   2'd1, 32'h0, 32'h0000_5AAD, 1'b0, 32'h5AAD_0000, 1'b0);
        single("misalign",  1'b0, 32'h11,   2'd2, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
        single("siz_big",   1'b0, 32'h0,    2'd3, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
        single("wr_top",    1'b1, 32'hFFC,  2'd2, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0, 1'b0);
        single("wr_oor",    1'b1, 32'h1000, 2'd2, 32'h1234_5678, 32'h0, 1'b1, 32'h0, 1'b1);
        single("rd_top",    1'b0, 32'hFFC,  2'd2, 32'h0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);
        single("rd_zero",   1'b0, 32'h0,    2'd2, 32'h0, 32'hC0DE_0000, 1'b0, 32'hC0DE_0000, 1'b0);
        single("rd_lastb",  1'b0, 32'hFFF,  2'd0, 32'h0, 32'h0000_00CA, 1'b0, 32'hCA00_0000, 1'b0);
        single("rd_lasth",  1'b0, 32'hFFE,  2'd1, 32'h0, 32'h0000_CAFE, 1'b0, 32'hCAFE_0000, 1'b0);
        single("rd_wrap",   1'b0, 32'hFFFF_FFFC, 2'd2, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
        // Reset with two reads in flight.
        c0 = obs_cnt[0];
        c1 = obs_cnt[1];
        wait_rdy();
        vld = 1'b1; wen = 1'b0; siz = 2'd2; adr = 32'h10;
        tick();
        adr = 32'h14;
        tick();
        vld = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("rst_flight/cnt0", obs_cnt[0] - c0, 32'd1);
        chk("rst_flight/cnt1", obs_cnt[1] - c1, 32'd0);
        single("rd_after_rst", 1'b0, 32'h10, 2'd2, 32'h0, 32'h5AAD_BEEF, 1'b0, 32'h5AAD_BEEF, 1'b0);
        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            vld = ($urandom_range(3, 0) != 0);
            wen = 1'($urandom_range(1, 0));
            cmd = tcb_req_cmd_def_t'(3'($urandom_range(7, 0)));
            r   = int'($urandom_range(7, 0));
            adr = (r < 6) ? 32'($urandom_range(63, 0)) :
                  (r == 6) ? 32'(32'hFC0 + $urandom_range(63, 0)) : 32'($urandom);
            siz = 2'($urandom_range(3, 0));
            wdt = 32'($urandom);
            tick();
        end
        vld = 1'b0;
        repeat (6) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
